// File: rtl/udp_rx_packer.sv
// Packs each byte-serial UDP payload burst into one wide word and holds it
// for a valid/ready consumer, flagging truncation, length mismatch and drops.
module udp_rx_packer #(
  parameter int DATA_W = 960,
  parameter int LEN_W  = 16
) (
  input  logic              rgmii_clk,
  input  logic              rstn,
  input  logic              udp_rec_data_valid,
  input  logic [7:0]        udp_rec_rdata,
  input  logic [LEN_W-1:0]  udp_rec_data_length,
  output logic              rx_pkt_valid,
  input  logic              rx_pkt_ready,
  output logic [DATA_W-1:0] rx_pkt_data,
  output logic [LEN_W-1:0]  rx_pkt_length,
  output logic              rx_pkt_trunc,
  output logic              rx_pkt_len_err,
  output logic [LEN_W-1:0]  rx_drop_cnt
);

  localparam int MAX_BYTES = DATA_W / 8;

  typedef enum logic [2:0] {
    WAIT_GAP,
    IDLE,
    COLLECT,
    HOLD,
    DROP
  } state_e;

  state_e state_q, state_d;

  // Lane MAX_BYTES-1 sits in the top byte, so byte index i lives in lane MAX_BYTES-1-i.
  logic [MAX_BYTES-1:0][7:0] data_q, data_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          olen_q, olen_d;
  logic                      trunc_q, trunc_d;
  logic                      lerr_q, lerr_d;
  logic                      valid_q, valid_d;
  logic [LEN_W-1:0]          drop_q, drop_d;

  logic [LEN_W-1:0] cnt_inc;
  logic [LEN_W-1:0] drop_inc;
  logic [LEN_W-1:0] pay_len;
  logic             len_short;
  logic             lerr_now;
  logic             trunc_now;

  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);
  assign drop_inc  = (drop_q == '1) ? drop_q : drop_q + LEN_W'(1);
  assign pay_len   = len_q - LEN_W'(8);
  assign len_short = (len_q < LEN_W'(8));
  // Mismatch is judged on the full burst count, not the stored byte count.
  assign lerr_now  = len_short | (cnt_q != pay_len);
  assign trunc_now = (cnt_q > LEN_W'(MAX_BYTES));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    olen_d  = olen_q;
    trunc_d = trunc_q;
    lerr_d  = lerr_q;
    drop_d  = drop_q;
    valid_d = valid_q & ~rx_pkt_ready;

    case (state_q)
      WAIT_GAP: begin
        if (!udp_rec_data_valid) state_d = IDLE;
      end

      IDLE: begin
        if (udp_rec_data_valid) begin
          data_d              = '0;
          data_d[MAX_BYTES-1] = udp_rec_rdata;
          cnt_d               = LEN_W'(1);
          len_d               = udp_rec_data_length;
          state_d             = COLLECT;
        end
      end

      COLLECT: begin
        if (udp_rec_data_valid) begin
          for (int i = 1; i < MAX_BYTES; i++) begin
            if (cnt_q == LEN_W'(i)) data_d[MAX_BYTES-1-i] = udp_rec_rdata;
          end
          cnt_d = cnt_inc;
        end else begin
          olen_d  = cnt_q;
          trunc_d = trunc_now;
          lerr_d  = lerr_now;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        if (udp_rec_data_valid) begin
          if (rx_pkt_ready) begin
            // Handshake and a new burst in the same cycle: nothing is lost.
            data_d              = '0;
            data_d[MAX_BYTES-1] = udp_rec_rdata;
            cnt_d               = LEN_W'(1);
            len_d               = udp_rec_data_length;
            state_d             = COLLECT;
          end else begin
            drop_d  = drop_inc;
            state_d = DROP;
          end
        end else if (rx_pkt_ready) begin
          state_d = IDLE;
        end
      end

      DROP: begin
        if (!udp_rec_data_valid) state_d = valid_d ? HOLD : IDLE;
      end

      default: state_d = WAIT_GAP;
    endcase
  end

  always_ff @(posedge rgmii_clk) begin
    if (!rstn) begin
      state_q <= WAIT_GAP;
      data_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      olen_q  <= '0;
      trunc_q <= 1'b0;
      lerr_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      olen_q  <= olen_d;
      trunc_q <= trunc_d;
      lerr_q  <= lerr_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign rx_pkt_valid   = valid_q;
  assign rx_pkt_data    = data_q;
  assign rx_pkt_length  = olen_q;
  assign rx_pkt_trunc   = trunc_q;
  assign rx_pkt_len_err = lerr_q;
  assign rx_drop_cnt    = drop_q;

endmodule

// File: doc/udp_rx_packer.md
Name: udp_rx_packer

Overview:
Receive-side counterpart of the wide UDP send path. Takes the byte-serial UDP payload stream produced by the UDP stack (udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length) in the rgmii_clk domain. Packs each datagram into one DATA_W-bit word and presents it to user logic with a valid/ready handshake. Also reports byte count, truncation, length mismatch and dropped-packet count.

Parameters:
DATA_W, 960, width of the packed payload word; must be a multiple of 8 (MAX_BYTES = DATA_W/8 = 120)
LEN_W, 16, width of length and counter fields

Ports:
rgmii_clk  in  1  single clock for all logic
rstn  in  1  synchronous, active-low reset
udp_rec_data_valid  in  1  high for every payload byte of a datagram, contiguous per datagram
udp_rec_rdata  in  8  payload byte, qualified by udp_rec_data_valid
udp_rec_data_length  in  LEN_W  UDP length field (payload + 8); stable while udp_rec_data_valid is high
rx_pkt_valid  out  1  packed datagram available
rx_pkt_ready  in  1  consumer accepts the datagram when high together with rx_pkt_valid
rx_pkt_data  out  DATA_W  packed payload; first byte at [DATA_W-1 -: 8]; unused low bytes zero
rx_pkt_length  out  LEN_W  payload bytes counted during the burst; saturates at all-ones
rx_pkt_trunc  out  1  count > MAX_BYTES; bytes beyond MAX_BYTES discarded
rx_pkt_len_err  out  1  count != udp_rec_data_length - 8, using the length sampled on the first byte
rx_drop_cnt  out  LEN_W  saturating count of datagrams dropped because the buffer was occupied

Behaviour:
- Reset (rstn low at a clock edge): all outputs and internal counters go to 0 and the FSM enters WAIT_GAP. Any in-progress packet is abandoned.
- FSM states: WAIT_GAP, IDLE, COLLECT, HOLD, DROP.
- WAIT_GAP:
  - Go to IDLE on the first cycle with udp_rec_data_valid low.
  - Prevents capture of a partial burst after reset release.
- IDLE:
  - udp_rec_data_valid high → clear the data register.
  - Write the byte to index 0, set count = 1, sample udp_rec_data_length, go to COLLECT.
- COLLECT, udp_rec_data_valid high:
  - Byte at index count is written to [DATA_W-1-8*count -: 8] if count < MAX_BYTES; otherwise it is discarded.
  - count increments, saturating at all-ones.
- COLLECT, udp_rec_data_valid low:
  - End of datagram. Register length, trunc and len_err.
  - Go to HOLD; rx_pkt_valid is high from the next cycle.
  - Latency: last byte at cycle N → rx_pkt_valid high in cycle N+2.
- HOLD:
  - rx_pkt_valid = 1. rx_pkt_data, length and flags are stable until the handshake.
  - rx_pkt_ready high → handshake; rx_pkt_valid drops the next cycle and the FSM goes to IDLE.
  - New burst starts (udp_rec_data_valid high) and rx_pkt_ready high in the same cycle → handshake completes and the new byte starts a fresh COLLECT; nothing is dropped.
  - New burst starts and rx_pkt_ready low → rx_drop_cnt increments (saturating), go to DROP.
- DROP:
  - Burst bytes are ignored. rx_pkt_valid stays asserted and the held datagram is unchanged.
  - A handshake may occur in DROP; it clears rx_pkt_valid the next cycle.
  - When udp_rec_data_valid goes low: go to HOLD if the held datagram is still unaccepted, else IDLE.
- Length checks:
  - len_err uses the full count, not the truncated count.
  - A sampled length below 8 always sets len_err.
- Zero-length datagrams cannot be observed; no output is produced for them.
- rx_pkt_valid never deasserts without a handshake, except on reset.

Test Plan:
- 4 bytes DE AD BE EF, length 12 → rx_pkt_data[959:928]=32'hDEADBEEF, rest 0, rx_pkt_length=4, trunc=0, len_err=0, valid 2 cycles after last byte.
- 130-byte burst 00..81, length 138 → rx_pkt_length=130, trunc=1, len_err=0, bytes 00..77 packed MSB-first, 78..81 absent.
- Packet A held (ready low), packet B 6 bytes arrives → rx_drop_cnt=1, data still A. Ready asserted mid-B → valid low. After B ends → IDLE; packet C is received normally.
- A held; rx_pkt_ready high in the same cycle as B's first byte → A accepted, B collected completely, drop_cnt=0.
- rstn low during byte 3 of a 10-byte burst, released while burst continues → outputs 0, remainder ignored (WAIT_GAP), next 5-byte packet received with length 5.
- 5 bytes with udp_rec_data_length=12 → len_err=1; then 2 bytes with length 4 → len_err=1.
